// File: rtl/rv_multicycle_controller.sv
// ---------------------------------------------------------------------------
// rv_multicycle_controller
//
// Main control FSM of the multicycle RISC-V datapath. Each instruction is
// walked through fetch, decode, execute, memory and writeback states. The
// instruction and data accesses share one memory, and a mem_ready handshake
// stalls the FSM in FETCH, MEM_READ and MEM_WRITE.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (forces every output to 0)
//   op         IR[6:0] of the held instruction
//   funct3     IR[14:12] of the held instruction
//   zero, neg  ALU flags used for the branch decision
//   mem_ready  memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite    datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc      datapath mux selects
//   illegal    sticky flag, set once an unsupported opcode has been decoded
// ---------------------------------------------------------------------------
module rv_multicycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       neg,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       illegal
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR,
      S_LUI, S_ILLEGAL
   } state_t;

   state_t state;
   state_t state_next;
   logic   illegal_q;
   logic   branch_taken;

   // NOTE: every always_comb variable gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:     if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = S_MEM_ADR;
               OP_R:         state_next = S_EXEC_R;
               OP_IALU:      state_next = S_EXEC_I;
               OP_BR:        state_next = S_BRANCH;
               OP_JAL:       state_next = S_JAL;
               OP_JALR:      state_next = S_JALR_ADR;
               OP_LUI:       state_next = S_LUI;
               default:      state_next = S_ILLEGAL;
            endcase
         end
         S_MEM_ADR:   state_next = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
         S_MEM_WB:    state_next = S_FETCH;
         S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
         S_EXEC_R:    state_next = S_ALU_WB;
         S_EXEC_I:    state_next = S_ALU_WB;
         S_ALU_WB:    state_next = S_FETCH;
         S_BRANCH:    state_next = S_FETCH;
         S_JAL:       state_next = S_ALU_WB;
         S_JALR_ADR:  state_next = S_JALR;
         S_JALR:      state_next = S_ALU_WB;
         S_LUI:       state_next = S_FETCH;
         S_ILLEGAL:   state_next = S_ILLEGAL;
         default:     state_next = S_FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == S_ILLEGAL) illegal_q <= 1'b1;
      end
   end

   // Branch compare: beq/bne from zero, blt/bge from the signed sign flag.
   always_comb begin
      case (funct3)
         3'b000:  branch_taken = zero;
         3'b001:  branch_taken = ~zero;
         3'b100:  branch_taken = neg;
         3'b101:  branch_taken = ~neg;
         default: branch_taken = 1'b0;
      endcase
   end

   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ImmSrc    = 3'b000;
      illegal   = 1'b0;
      // Reset silences everything, including the op-driven ImmSrc decode.
      if (!rst) begin
         case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_LUI:  ImmSrc = 3'b011;
            OP_JAL:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
         endcase
         illegal = illegal_q;
         case (state)
            S_FETCH: begin
               // PC+4 is computed every cycle but only committed with the IR.
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            S_DECODE: begin
               // Precompute OldPC+imm into ALUOut for branch/jal targets.
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
            end
            S_MEM_ADR, S_JALR_ADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
            end
            S_MEM_READ: AdrSrc = 1'b1;
            S_MEM_WB: begin
               ResultSrc = 2'b01;
               RegWrite  = 1'b1;
            end
            S_MEM_WRITE: begin
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
            end
            S_EXEC_R: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ALUOp   = 2'b10;
            end
            S_ALU_WB: RegWrite = 1'b1;
            S_BRANCH: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b01;
               PCWrite = branch_taken;
            end
            S_JAL, S_JALR: begin
               // Jump to ALUOut while the ALU forms OldPC+4 for the link.
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               PCWrite = 1'b1;
            end
            S_LUI: begin
               ResultSrc = 2'b11;
               RegWrite  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_rv_multicycle_controller
//
// Self-checking bench. For each instruction a reference model builds the
// expected per-cycle control vector as a recipe of phases (fetch with stalls,
// decode, then the instruction-specific steps), and the bench replays it,
// driving mem_ready and comparing every output one time unit after the
// falling edge.
// ---------------------------------------------------------------------------
module tb_rv_multicycle_controller;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BAD  = 7'b1111111;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] aop;
      logic [2:0] imm;
      logic       ill;
   } ctl_t;

   typedef struct {
      ctl_t c;
      logic mr;
   } step_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       zero;
   logic       neg;
   logic       mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0] ImmSrc;

   int checks = 0;
   int errors = 0;
   step_t exp_q[$];
   logic [6:0] valid_ops [8] = '{OP_LW, OP_SW, OP_R, OP_IALU, OP_BR, OP_JAL, OP_JALR, OP_LUI};

   rv_multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .neg(neg),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] imm_of(input logic [6:0] opc);
      case (opc)
         OP_SW:   return 3'b001;
         OP_BR:   return 3'b010;
         OP_LUI:  return 3'b011;
         OP_JAL:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic ctl_t mk(input logic pcw, input logic adr, input logic mw,
                               input logic irw, input logic rw, input logic [1:0] rs,
                               input logic [1:0] sa, input logic [1:0] sb,
                               input logic [1:0] aop, input logic [6:0] opc);
      ctl_t c;
      c = '{pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm_of(opc), 1'b0};
      return c;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input ctl_t c, input logic mr);
      step_t s;
      s.c = c;
      s.mr = mr;
      exp_q.push_back(s);
   endtask

   // Reference recipe: fetch (fs stall cycles), decode, then the steps the
   // instruction class needs. ms is the stall count of a data access.
   task automatic build_trace(input logic [6:0] opc, input logic [2:0] f3,
                              input logic z, input logic n, input int fs, input int ms);
      logic taken;
      ctl_t c;
      exp_q.delete();
      for (int i = 0; i <= fs; i++)
         push(mk(i == fs, 0, 0, i == fs, 0, 2'b10, 2'b00, 2'b10, 2'b00, opc), i == fs);
      push(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, opc), rnd_bit());
      case (opc)
         OP_LW: begin
            push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, opc), rnd_bit());
            for (int i = 0; i <= ms; i++)
               push(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, opc), i == ms);
            push(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, opc), rnd_bit());
         end
         OP_SW: begin
            push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, opc), rnd_bit());
            for (int i = 0; i <= ms; i++)
               push(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, opc), i == ms);
         end
         OP_R, OP_IALU: begin
            push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (opc == OP_R) ? 2'b00 : 2'b01, 2'b10, opc),
                 rnd_bit());
            push(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, opc), rnd_bit());
         end
         OP_BR: begin
            taken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z :
                    (f3 == 3'd4) ? n : (f3 == 3'd5) ? !n : 1'b0;
            push(mk(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, opc), rnd_bit());
         end
         OP_JAL, OP_JALR: begin
            if (opc == OP_JALR)
               push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, opc), rnd_bit());
            push(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, opc), rnd_bit());
            push(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, opc), rnd_bit());
         end
         OP_LUI:
            push(mk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, opc), rnd_bit());
         default: begin
            c = '0;
            c.imm = imm_of(opc);
            c.ill = 1'b1;
            for (int i = 0; i < 10; i++) push(c, rnd_bit());
         end
      endcase
   endtask

   // Replays the first n expected cycles (all of them when n < 0).
   task automatic play(input string tag, input int n);
      int   lim;
      ctl_t obs;
      lim = (n < 0 || n > exp_q.size()) ? exp_q.size() : n;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         rst = 1'b0;
         mem_ready = exp_q[i].mr;
         #1;
         obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};
         checks++;
         if (obs !== exp_q[i].c) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h (op=%b f3=%b)",
                     tag, i, obs, exp_q[i].c, op, funct3);
         end
      end
   endtask

   task automatic do_reset(input string tag, input int n);
      ctl_t obs;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b1;
         mem_ready = 1'b1;
         #1;
         obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};
         checks++;
         if (obs !== ctl_t'(0)) begin
            errors++;
            $display("FAIL %s reset cycle %0d: got %h expected 0", tag, i, obs);
         end
      end
   endtask

   task automatic run(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                      input logic z, input logic n, input int fs, input int ms);
      op = opc;
      funct3 = f3;
      zero = z;
      neg = n;
      build_trace(opc, f3, z, n, fs, ms);
      play(tag, -1);
   endtask

   task automatic test_reset_add();
      op = OP_R;
      do_reset("reset", 2);
      run("add", OP_R, 3'd0, 0, 0, 0, 0);
      run("addi_fetch_stall", OP_IALU, 3'd0, 0, 0, 2, 0);
   endtask

   task automatic test_lw_stall();
      run("lw_stall", OP_LW, 3'd2, 0, 0, 0, 3);
   endtask

   task automatic test_sw();
      run("sw", OP_SW, 3'd2, 0, 0, 1, 2);
   endtask

   task automatic test_branches();
      run("beq_taken", OP_BR, 3'b000, 1, 0, 0, 0);
      run("bne_not_taken", OP_BR, 3'b001, 1, 0, 0, 0);
      run("bge_taken", OP_BR, 3'b101, 0, 0, 0, 0);
      run("f3_010_not_taken", OP_BR, 3'b010, 1, 1, 0, 0);
      run("blt_taken", OP_BR, 3'b100, 0, 1, 0, 0);
   endtask

   task automatic test_jumps_lui();
      run("jal", OP_JAL, 3'd0, 0, 0, 0, 0);
      run("jalr", OP_JALR, 3'd0, 0, 0, 0, 0);
      run("lui", OP_LUI, 3'd0, 0, 0, 0, 0);
   endtask

   task automatic test_illegal_and_reset();
      run("illegal", OP_BAD, 3'd0, 0, 0, 0, 0);
      do_reset("reset_from_illegal", 1);
      run("add_after_illegal", OP_R, 3'd0, 0, 0, 0, 0);
      // Abort a stalled store after two MemWrite cycles.
      op = OP_SW;
      funct3 = 3'd2;
      build_trace(OP_SW, 3'd2, 0, 0, 0, 5);
      play("sw_abort", 5);
      do_reset("reset_mid_store", 1);
      run("add_after_abort", OP_R, 3'd0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++)
         run("random", valid_ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
             rnd_bit(), rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3));
   endtask

   initial begin
      rst = 1'b1;
      mem_ready = 1'b0;
      op = OP_R;
      funct3 = 3'd0;
      zero = 1'b0;
      neg = 1'b0;
      test_reset_add();
      test_lw_stall();
      test_sw();
      test_branches();
      test_jumps_lui();
      test_illegal_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
